spec_rf: RTL and testbench

Parametrised speculative register file: the next generation of the current merged result buffer and register file.
- Execution results enter an age-ordered result buffer tagged with memory order and branch level. They retire in order into the architectural array once both tags reach zero.
- Multiple read ports bypass from the late memory port, then the youngest buffer entry, then the array.
- New versus the current block: back-pressure (in_ready), in-order retirement capped at RET_N per cycle, per-port committed-only read mode, and registered occupancy and pending-register outputs.

---
 rtl/spec_rf_pkg.sv | 31 +++
 rtl/spec_rf_lookup.sv | 34 +++
 rtl/spec_rf.sv | 191 +++++++++++++++++++
 tb/tb_spec_rf.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_rf_pkg.sv
// Shared constants and helpers for the speculative register file:
// default geometry, counter widths and the saturating tag decrement.
package spec_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RGBIT_DEF = 5;
  localparam int WR_N_DEF  = 4;
  localparam int RD_N_DEF  = 8;
  localparam int DEPTH_DEF = 8;
  localparam int RET_N_DEF = 2;
  localparam int ORD_W_DEF = 3;
  localparam int LVL_W_DEF = 2;

  // Widest order/level tag the shared decrement helper handles.
  localparam int TAG_MAX_W = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [TAG_MAX_W-1:0] sub_tag(input logic [TAG_MAX_W-1:0] tag,
                                                   input logic dec);
    if (dec && (tag != '0)) return tag - TAG_MAX_W'(1);
    return tag;
  endfunction

endpackage

// File: rtl/spec_rf_lookup.sv
// One read port's search of the result buffer: the youngest valid entry
// matching the index wins, optionally ignoring speculative (level!=0) entries.
module spec_rf_lookup
  import spec_rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RGBIT = RGBIT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int LVL_W = LVL_W_DEF
) (
  input  logic [RGBIT-1:0]       rd_sel,
  input  logic                   commit_only,
  input  logic [DEPTH-1:0]       ent_vld,
  input  logic [DEPTH*RGBIT-1:0] ent_sel,
  input  logic [DEPTH*LVL_W-1:0] ent_lvl,
  input  logic [DEPTH*XLEN-1:0]  ent_data,
  output logic                   hit,
  output logic [XLEN-1:0]        hit_data
);

  // Entries are age ordered (index 0 oldest), so the last match is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_sel[i*RGBIT +: RGBIT] == rd_sel) &&
          (!commit_only || (ent_lvl[i*LVL_W +: LVL_W] == '0))) begin
        hit      = 1'b1;
        hit_data = ent_data[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/spec_rf.sv
// Speculative register file: age-ordered result buffer retiring in order
// into the architectural array, with late-port and buffer bypass on reads.
module spec_rf
  import spec_rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RGBIT = RGBIT_DEF,
  parameter int WR_N  = WR_N_DEF,
  parameter int RD_N  = RD_N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int RET_N = RET_N_DEF,
  parameter int ORD_W = ORD_W_DEF,
  parameter int LVL_W = LVL_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WR_N*RGBIT-1:0]     in_sel,
  input  logic [WR_N*ORD_W-1:0]     in_order,
  input  logic [WR_N*LVL_W-1:0]     in_level,
  input  logic [WR_N*XLEN-1:0]      in_data,
  output logic                      in_ready,
  input  logic                      mem_release,
  input  logic                      level_decrease,
  input  logic                      level_clear,
  input  logic                      flush,
  input  logic [RGBIT-1:0]          late_sel,
  input  logic [XLEN-1:0]           late_data,
  input  logic [RD_N*RGBIT-1:0]     rd_sel,
  input  logic [RD_N-1:0]           rd_commit_only,
  output logic [RD_N*XLEN-1:0]      rd_data,
  output logic [$clog2(DEPTH+1)-1:0] buf_count,
  output logic [2**RGBIT-1:0]       pend_mask
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int IDX_W = idx_width(DEPTH);
  localparam int NREG  = 2**RGBIT;

  logic [RGBIT-1:0] sel_q [DEPTH];
  logic [RGBIT-1:0] sel_d [DEPTH];
  logic [ORD_W-1:0] ord_q [DEPTH];
  logic [ORD_W-1:0] ord_d [DEPTH];
  logic [LVL_W-1:0] lvl_q [DEPTH];
  logic [LVL_W-1:0] lvl_d [DEPTH];
  logic [XLEN-1:0]  dat_q [DEPTH];
  logic [XLEN-1:0]  dat_d [DEPTH];
  logic [XLEN-1:0]  arr_q [NREG];
  logic [XLEN-1:0]  arr_d [NREG];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]  pend_q, pend_d;

  logic [ORD_W-1:0] ent_ord_up [DEPTH];
  logic [LVL_W-1:0] ent_lvl_up [DEPTH];
  logic [DEPTH-1:0] ent_kill;
  logic [DEPTH-1:0] ent_vld;
  logic [ORD_W-1:0] in_ord_up [WR_N];
  logic [LVL_W-1:0] in_lvl_up [WR_N];
  logic [WR_N-1:0]  in_kill;

  assign in_ready  = (cnt_q <= CNT_W'(DEPTH - WR_N));
  assign buf_count = cnt_q;
  assign pend_mask = pend_q;

  // Tag update and kill decision; the flush term spares only entries about to retire.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i]    = (CNT_W'(i) < cnt_q);
      ent_ord_up[i] = ORD_W'(sub_tag(TAG_MAX_W'(ord_q[i]), mem_release));
      ent_lvl_up[i] = LVL_W'(sub_tag(TAG_MAX_W'(lvl_q[i]), level_decrease));
      ent_kill[i]   = (flush && !((ent_ord_up[i] == '0) && (lvl_q[i] == '0))) ||
                      (level_clear && (lvl_q[i] != '0));
    end
    for (int j = 0; j < WR_N; j++) begin
      in_ord_up[j] = ORD_W'(sub_tag(TAG_MAX_W'(in_order[j*ORD_W +: ORD_W]), mem_release));
      in_lvl_up[j] = LVL_W'(sub_tag(TAG_MAX_W'(in_level[j*LVL_W +: LVL_W]), level_decrease));
      in_kill[j]   = (flush && !((in_ord_up[j] == '0) && (in_lvl_up[j] == '0))) ||
                     (level_clear && (in_level[j*LVL_W +: LVL_W] != '0));
    end
  end

  // Retire the eligible prefix, compact survivors, then append accepted slots.
  always_comb begin
    logic [CNT_W-1:0] n;
    int               nret;
    logic             run;
    sel_d  = sel_q;
    ord_d  = ord_q;
    lvl_d  = lvl_q;
    dat_d  = dat_q;
    arr_d  = arr_q;
    pend_d = '0;
    n      = '0;
    nret   = 0;
    run    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (run && ent_vld[i] && !ent_kill[i] && (ent_ord_up[i] == '0) &&
          (ent_lvl_up[i] == '0) && (nret < RET_N)) begin
        nret = nret + 1;
        if (sel_q[i] != '0) arr_d[sel_q[i]] = dat_q[i];
      end else begin
        run = 1'b0;
        if (ent_vld[i] && !ent_kill[i]) begin
          sel_d[n[IDX_W-1:0]] = sel_q[i];
          ord_d[n[IDX_W-1:0]] = ent_ord_up[i];
          lvl_d[n[IDX_W-1:0]] = ent_lvl_up[i];
          dat_d[n[IDX_W-1:0]] = dat_q[i];
          if (ent_ord_up[i] == '0) pend_d[sel_q[i]] = 1'b1;
          n = n + CNT_W'(1);
        end
      end
    end
    for (int j = 0; j < WR_N; j++) begin
      if (in_ready && (in_sel[j*RGBIT +: RGBIT] != '0) && !in_kill[j]) begin
        sel_d[n[IDX_W-1:0]] = in_sel[j*RGBIT +: RGBIT];
        ord_d[n[IDX_W-1:0]] = in_ord_up[j];
        lvl_d[n[IDX_W-1:0]] = in_lvl_up[j];
        dat_d[n[IDX_W-1:0]] = in_data[j*XLEN +: XLEN];
        n = n + CNT_W'(1);
      end
    end
    if (late_sel != '0) arr_d[late_sel] = late_data;
    cnt_d = n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
      for (int r = 0; r < NREG; r++) arr_q[r] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      arr_q  <= arr_d;
    end
  end

  // Payload needs no reset: cnt_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    sel_q <= sel_d;
    ord_q <= ord_d;
    lvl_q <= lvl_d;
    dat_q <= dat_d;
  end

  logic [DEPTH*RGBIT-1:0] ent_sel_flat;
  logic [DEPTH*LVL_W-1:0] ent_lvl_flat;
  logic [DEPTH*XLEN-1:0]  ent_dat_flat;
  logic [RD_N-1:0]        port_hit;
  logic [XLEN-1:0]        port_hit_data [RD_N];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_sel_flat[i*RGBIT +: RGBIT] = sel_q[i];
      ent_lvl_flat[i*LVL_W +: LVL_W] = lvl_q[i];
      ent_dat_flat[i*XLEN +: XLEN]   = dat_q[i];
    end
  end

  for (genvar p = 0; p < RD_N; p++) begin : g_port
    spec_rf_lookup #(
      .XLEN (XLEN),
      .RGBIT(RGBIT),
      .DEPTH(DEPTH),
      .LVL_W(LVL_W)
    ) u_lookup (
      .rd_sel     (rd_sel[p*RGBIT +: RGBIT]),
      .commit_only(rd_commit_only[p]),
      .ent_vld    (ent_vld),
      .ent_sel    (ent_sel_flat),
      .ent_lvl    (ent_lvl_flat),
      .ent_data   (ent_dat_flat),
      .hit        (port_hit[p]),
      .hit_data   (port_hit_data[p])
    );
  end

  // Read priority: x0, late port, youngest buffer entry, array.
  always_comb begin
    for (int p = 0; p < RD_N; p++) begin
      if (rd_sel[p*RGBIT +: RGBIT] == '0)
        rd_data[p*XLEN +: XLEN] = '0;
      else if (late_sel == rd_sel[p*RGBIT +: RGBIT])
        rd_data[p*XLEN +: XLEN] = late_data;
      else if (port_hit[p])
        rd_data[p*XLEN +: XLEN] = port_hit_data[p];
      else
        rd_data[p*XLEN +: XLEN] = arr_q[rd_sel[p*RGBIT +: RGBIT]];
    end
  end

endmodule

// File: tb/tb_spec_rf.sv
// Self-checking bench for spec_rf: directed scenarios plus randomized traffic
// compared each cycle against a queue-based behavioural model.
module tb_spec_rf;

  localparam int XLEN  = 32;
  localparam int RGBIT = 5;
  localparam int WR_N  = 4;
  localparam int RD_N  = 8;
  localparam int DEPTH = 8;
  localparam int RET_N = 2;
  localparam int ORD_W = 3;
  localparam int LVL_W = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NREG  = 2**RGBIT;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [WR_N*RGBIT-1:0]  in_sel;
  logic [WR_N*ORD_W-1:0]  in_order;
  logic [WR_N*LVL_W-1:0]  in_level;
  logic [WR_N*XLEN-1:0]   in_data;
  logic                   in_ready;
  logic                   mem_release, level_decrease, level_clear, flush;
  logic [RGBIT-1:0]       late_sel;
  logic [XLEN-1:0]        late_data;
  logic [RD_N*RGBIT-1:0]  rd_sel;
  logic [RD_N-1:0]        rd_commit_only;
  logic [RD_N*XLEN-1:0]   rd_data;
  logic [CNT_W-1:0]       buf_count;
  logic [NREG-1:0]        pend_mask;

  spec_rf dut (
    .clk(clk), .rst(rst), .in_sel(in_sel), .in_order(in_order), .in_level(in_level),
    .in_data(in_data), .in_ready(in_ready), .mem_release(mem_release),
    .level_decrease(level_decrease), .level_clear(level_clear), .flush(flush),
    .late_sel(late_sel), .late_data(late_data), .rd_sel(rd_sel),
    .rd_commit_only(rd_commit_only), .rd_data(rd_data), .buf_count(buf_count),
    .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural array plus an age-ordered queue of results.
  typedef struct {
    logic [RGBIT-1:0] sel;
    int               ord;
    int               lvl;
    logic [XLEN-1:0]  data;
  } ent_t;

  logic [XLEN-1:0] m_arch [NREG];
  ent_t            bq[$];
  logic [NREG-1:0] m_pend;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_arch[r] = '0;
    bq.delete();
    m_pend = '0;
  endtask

  function automatic logic [XLEN-1:0] m_read(input logic [RGBIT-1:0] s, input logic co);
    if (s == 0) return '0;
    if (late_sel == s) return late_data;
    for (int i = bq.size() - 1; i >= 0; i--)
      if (bq[i].sel == s && (!co || bq[i].lvl == 0)) return bq[i].data;
    return m_arch[s];
  endfunction

  task automatic model_step();
    ent_t            nq[$];
    ent_t            e;
    int              retired = 0;
    bit              blocked = 0;
    bit              ready;
    bit              kill;
    int              ou, lu, o, l;
    logic [NREG-1:0] pend = '0;
    ready = (bq.size() <= DEPTH - WR_N);
    foreach (bq[i]) begin
      ou   = (mem_release && bq[i].ord > 0) ? bq[i].ord - 1 : bq[i].ord;
      lu   = (level_decrease && bq[i].lvl > 0) ? bq[i].lvl - 1 : bq[i].lvl;
      kill = (flush && !(ou == 0 && bq[i].lvl == 0)) || (level_clear && bq[i].lvl != 0);
      if (!blocked && !kill && ou == 0 && lu == 0 && retired < RET_N) begin
        m_arch[bq[i].sel] = bq[i].data;
        retired++;
      end else begin
        blocked = 1;
        if (!kill) begin
          e = bq[i]; e.ord = ou; e.lvl = lu;
          nq.push_back(e);
          if (ou == 0) pend[e.sel] = 1'b1;
        end
      end
    end
    if (ready) begin
      for (int j = 0; j < WR_N; j++) begin
        o  = int'(in_order[j*ORD_W +: ORD_W]);
        l  = int'(in_level[j*LVL_W +: LVL_W]);
        ou = (mem_release && o > 0) ? o - 1 : o;
        lu = (level_decrease && l > 0) ? l - 1 : l;
        kill = (flush && !(ou == 0 && lu == 0)) || (level_clear && l != 0);
        if (in_sel[j*RGBIT +: RGBIT] != 0 && !kill) begin
          e.sel = in_sel[j*RGBIT +: RGBIT]; e.ord = ou; e.lvl = lu;
          e.data = in_data[j*XLEN +: XLEN];
          nq.push_back(e);
        end
      end
    end
    if (late_sel != 0) m_arch[late_sel] = late_data;
    bq     = nq;
    m_pend = pend;
  endtask

  task automatic check_outputs();
    chk("buf_count", 64'(buf_count), 64'(bq.size()));
    chk("in_ready", 64'(in_ready), 64'(bq.size() <= DEPTH - WR_N));
    chk("pend_mask", 64'(pend_mask), 64'(m_pend));
    for (int p = 0; p < RD_N; p++)
      chk($sformatf("rd%0d_x%0d", p, rd_sel[p*RGBIT +: RGBIT]), 64'(rd_data[p*XLEN +: XLEN]),
          64'(m_read(rd_sel[p*RGBIT +: RGBIT], rd_commit_only[p])));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    in_sel = '0; in_order = '0; in_level = '0; in_data = '0;
    mem_release = 0; level_decrease = 0; level_clear = 0; flush = 0;
    late_sel = '0; late_data = '0; rd_sel = '0; rd_commit_only = '0;
  endtask

  task automatic set_slot(input int j, input logic [RGBIT-1:0] s, input logic [ORD_W-1:0] o,
                          input logic [LVL_W-1:0] l, input logic [XLEN-1:0] d);
    in_sel[j*RGBIT +: RGBIT] = s;
    in_order[j*ORD_W +: ORD_W] = o;
    in_level[j*LVL_W +: LVL_W] = l;
    in_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input logic [RGBIT-1:0] s, input logic co);
    rd_sel[p*RGBIT +: RGBIT] = s;
    rd_commit_only[p] = co;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state: every register reads zero.
    for (int g = 0; g < NREG / RD_N; g++) begin
      for (int p = 0; p < RD_N; p++) set_rd(p, RGBIT'(g * RD_N + p), 1'b0);
      #1;
      chk("rst_cnt", 64'(buf_count), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd1);
      for (int p = 0; p < RD_N; p++) chk("rst_rd", 64'(rd_data[p*XLEN +: XLEN]), 64'd0);
      cycle();
    end

    // Single result passes through buffer, then lands in the array.
    clear_inputs(); set_slot(0, 5, 0, 0, 32'hAA); cycle();
    clear_inputs(); set_rd(0, 5, 0); #1;
    chk("x5_cnt1", 64'(buf_count), 64'd1);
    chk("x5_buf", 64'(rd_data[XLEN-1:0]), 64'hAA);
    cycle();
    clear_inputs(); set_rd(0, 5, 0); #1;
    chk("x5_cnt0", 64'(buf_count), 64'd0);
    chk("x5_arr", 64'(rd_data[XLEN-1:0]), 64'hAA);
    cycle();

    // Older pending memory op blocks a younger ready entry.
    clear_inputs(); set_slot(0, 3, 1, 0, 32'h33); set_slot(1, 4, 0, 0, 32'h44); cycle();
    clear_inputs(); cycle();
    clear_inputs(); #1;
    chk("blk_cnt", 64'(buf_count), 64'd2);
    chk("blk_pend", 64'(pend_mask), 64'(32'h10));
    mem_release = 1'b1; cycle();
    clear_inputs(); set_rd(0, 3, 0); set_rd(1, 4, 0); #1;
    chk("rel_cnt", 64'(buf_count), 64'd0);
    chk("rel_x3", 64'(rd_data[0 +: XLEN]), 64'h33);
    chk("rel_x4", 64'(rd_data[XLEN +: XLEN]), 64'h44);
    cycle();

    // Speculative entry, commit-only read, then mispredict kill.
    clear_inputs(); set_slot(0, 7, 0, 1, 32'h11); cycle();
    clear_inputs(); set_rd(0, 7, 0); set_rd(1, 7, 1); #1;
    chk("spec_rd", 64'(rd_data[0 +: XLEN]), 64'h11);
    chk("commit_rd", 64'(rd_data[XLEN +: XLEN]), 64'h0);
    level_clear = 1'b1; cycle();
    clear_inputs(); set_rd(0, 7, 0); #1;
    chk("clr_cnt", 64'(buf_count), 64'd0);
    chk("clr_rd", 64'(rd_data[0 +: XLEN]), 64'h0);
    cycle();

    // Back-pressure at five entries.
    clear_inputs();
    for (int j = 0; j < WR_N; j++) set_slot(j, RGBIT'(10 + j), 1, 0, XLEN'(32'h100 + j));
    cycle();
    clear_inputs(); set_slot(0, 14, 1, 0, 32'h104); cycle();
    clear_inputs(); set_slot(0, 15, 0, 0, 32'h105); #1;
    chk("bp_ready", 64'(in_ready), 64'd0);
    cycle();
    clear_inputs(); #1;
    chk("bp_cnt", 64'(buf_count), 64'd5);
    mem_release = 1'b1; cycle();
    clear_inputs(); repeat (4) cycle();

    // Retiring write and late write to the same register: late wins.
    clear_inputs(); set_slot(0, 9, 0, 0, 32'h1); cycle();
    clear_inputs(); late_sel = 9; late_data = 32'h2; set_rd(0, 9, 0); #1;
    chk("late_bypass", 64'(rd_data[0 +: XLEN]), 64'h2);
    cycle();
    clear_inputs(); set_rd(0, 9, 0); #1;
    chk("late_arr", 64'(rd_data[0 +: XLEN]), 64'h2);
    chk("late_cnt", 64'(buf_count), 64'd0);
    cycle();

    // Randomized traffic against the model, with occasional async reset.
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_cnt", 64'(buf_count), 64'd0);
        rst = 1'b1;
      end
      for (int j = 0; j < WR_N; j++)
        set_slot(j, ($urandom_range(0, 3) == 0) ? RGBIT'(0) : RGBIT'($urandom_range(1, NREG - 1)),
                 ORD_W'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2)),
                 LVL_W'($urandom_range(0, 2)), XLEN'($urandom));
      mem_release    = ($urandom_range(0, 2) == 0);
      level_decrease = ($urandom_range(0, 2) == 0);
      level_clear    = ($urandom_range(0, 19) == 0);
      flush          = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) begin
        late_sel  = RGBIT'($urandom_range(0, NREG - 1));
        late_data = XLEN'($urandom);
      end
      for (int p = 0; p < RD_N; p++)
        set_rd(p, RGBIT'($urandom_range(0, NREG - 1)), 1'($urandom_range(0, 1)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
